// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions for the multi-cycle MIPS core.
// Contents: CP0 register addresses, ExcCode values, Status bit indices and
// the exception FSM state encoding. No ports.
package cpu_defs;

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_BREAK   = 5'd9;
  localparam logic [4:0] EXC_TEQ     = 5'd13;

  // Status: global interrupt/exception enable plus one mask bit per source
  localparam int STATUS_IE  = 0;
  localparam int STATUS_SYS = 1;
  localparam int STATUS_BRK = 2;
  localparam int STATUS_TEQ = 3;

  // Exception-entry FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SAVE  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

endpackage

// File: rtl/cp0_regfile_if.sv
// CP0 register-file bus: MFC0 read port, MTC0 write port, exception
// REQ/ACK handshake with the main controller, ERET strobe and status taps.
// master = controller/datapath side, slave = cp0_regfile.
interface cp0_regfile_if;
  logic [4:0]  CP0_R_ADDR;
  logic [31:0] CP0_RDATA;
  logic        MTC0_WE;
  logic [4:0]  CP0_W_ADDR;
  logic [31:0] CP0_WDATA;
  logic        EXC_REQ;
  logic [4:0]  EXC_CODE;
  logic [31:0] EXC_PC;
  logic        ERET;
  logic        EXC_ACK;
  logic        EXC_TAKEN;
  logic [31:0] EXC_TARGET;
  logic [31:0] STATUS_OUT;
  logic [31:0] EPC_OUT;

  modport master (
    output CP0_R_ADDR, MTC0_WE, CP0_W_ADDR, CP0_WDATA,
           EXC_REQ, EXC_CODE, EXC_PC, ERET,
    input  CP0_RDATA, EXC_ACK, EXC_TAKEN, EXC_TARGET, STATUS_OUT, EPC_OUT
  );

  modport slave (
    input  CP0_R_ADDR, MTC0_WE, CP0_W_ADDR, CP0_WDATA,
           EXC_REQ, EXC_CODE, EXC_PC, ERET,
    output CP0_RDATA, EXC_ACK, EXC_TAKEN, EXC_TARGET, STATUS_OUT, EPC_OUT
  );
endinterface

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: Status(12), Cause(13), EPC(14).
// Sequences exception entry (IDLE -> SAVE -> SHIFT -> ACK) with a REQ/ACK
// handshake and performs the ERET status restore.
// Ports:
//   CLK    - clock, all state on rising edge
//   RST_N  - synchronous active-low reset
//   bus    - cp0_regfile_if.slave (read/write ports, exception handshake,
//            ERET strobe, Status/EPC taps)
module cp0_regfile
  import cpu_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
  parameter logic [31:0] STATUS_RESET = 32'h0000_000F
) (
  input  logic          CLK,
  input  logic          RST_N,
  cp0_regfile_if.slave  bus
);

  logic [1:0]  state_reg, state_next;
  logic [31:0] status_reg, status_next;
  logic [31:0] cause_reg, cause_next;
  logic [31:0] epc_reg, epc_next;
  logic [31:0] pc_lat_reg, pc_lat_next;
  logic [4:0]  code_lat_reg, code_lat_next;
  logic        taken_reg, taken_next;

  // Source is accepted only if globally enabled and its own mask bit is set;
  // unknown codes are never accepted.
  function automatic logic exc_accepted(input logic [3:0] st, input logic [4:0] code);
    case (code)
      EXC_SYSCALL: return st[STATUS_IE] & st[STATUS_SYS];
      EXC_BREAK:   return st[STATUS_IE] & st[STATUS_BRK];
      EXC_TEQ:     return st[STATUS_IE] & st[STATUS_TEQ];
      default:     return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_next    = state_reg;
    status_next   = status_reg;
    cause_next    = cause_reg;
    epc_next      = epc_reg;
    pc_lat_next   = pc_lat_reg;
    code_lat_next = code_lat_reg;
    taken_next    = taken_reg;

    // MTC0 first, so any FSM/ERET update below overrides it for that register
    if (bus.MTC0_WE) begin
      case (bus.CP0_W_ADDR)
        ADDR_STATUS: status_next = bus.CP0_WDATA;
        ADDR_CAUSE:  cause_next  = bus.CP0_WDATA;
        ADDR_EPC:    epc_next    = bus.CP0_WDATA;
        default:     ;
      endcase
    end

    case (state_reg)
      ST_IDLE: begin
        // Enable check uses pre-edge Status even if MTC0 writes it now
        if (bus.EXC_REQ) begin
          if (exc_accepted(status_reg[3:0], bus.EXC_CODE)) begin
            pc_lat_next   = bus.EXC_PC;
            code_lat_next = bus.EXC_CODE;
            state_next    = ST_SAVE;
          end else begin
            taken_next = 1'b0;
            state_next = ST_ACK;
          end
        end else if (bus.ERET) begin
          status_next = status_reg >> 5;
        end
      end
      ST_SAVE: begin
        epc_next   = pc_lat_reg;
        cause_next = {cause_reg[31:7], code_lat_reg, cause_reg[1:0]};
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        status_next = status_reg << 5;
        taken_next  = 1'b1;
        state_next  = ST_ACK;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg    <= ST_IDLE;
      status_reg   <= STATUS_RESET;
      cause_reg    <= 32'h0;
      epc_reg      <= 32'h0;
      pc_lat_reg   <= 32'h0;
      code_lat_reg <= 5'h0;
      taken_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      status_reg   <= status_next;
      cause_reg    <= cause_next;
      epc_reg      <= epc_next;
      pc_lat_reg   <= pc_lat_next;
      code_lat_reg <= code_lat_next;
      taken_reg    <= taken_next;
    end
  end

  always_comb begin
    case (bus.CP0_R_ADDR)
      ADDR_STATUS: bus.CP0_RDATA = status_reg;
      ADDR_CAUSE:  bus.CP0_RDATA = cause_reg;
      ADDR_EPC:    bus.CP0_RDATA = epc_reg;
      default:     bus.CP0_RDATA = 32'h0;
    endcase
  end

  assign bus.EXC_ACK    = (state_reg == ST_ACK);
  assign bus.EXC_TAKEN  = (state_reg == ST_ACK) & taken_reg;
  assign bus.EXC_TARGET = ((state_reg == ST_ACK) && taken_reg) ? EXC_VECTOR : epc_reg;
  assign bus.STATUS_OUT = status_reg;
  assign bus.EPC_OUT    = epc_reg;

endmodule

// File: tb/tb_cp0_regfile.sv
module tb_cp0_regfile;
  logic CLK = 1'b0;
  logic RST_N;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  cp0_regfile_if bus();

  cp0_regfile dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.CP0_R_ADDR = 5'd0;
    bus.MTC0_WE    = 1'b0;
    bus.CP0_W_ADDR = 5'd0;
    bus.CP0_WDATA  = 32'h0;
    bus.EXC_REQ    = 1'b0;
    bus.EXC_CODE   = 5'd0;
    bus.EXC_PC     = 32'h0;
    bus.ERET       = 1'b0;
  endtask

  task automatic read_reg(input logic [4:0] addr, output logic [31:0] data);
    bus.CP0_R_ADDR = addr;
    #1;
    data = bus.CP0_RDATA;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    @(negedge CLK);
    bus.MTC0_WE = 1'b1; bus.CP0_W_ADDR = addr; bus.CP0_WDATA = data;
    @(negedge CLK);
    bus.MTC0_WE = 1'b0;
    $display("txn mtc0 addr %0d data %h", addr, data);
  endtask

  // Raise a request (optionally with ERET in the same cycle) and wait,
  // bounded, for the ACK. lat = cycles from the sample edge to ACK visible.
  task automatic do_exc(input logic [4:0] code, input logic [31:0] pc, input logic eret,
                        output int lat, output logic taken, output logic [31:0] target);
    @(negedge CLK);
    bus.EXC_REQ = 1'b1; bus.EXC_CODE = code; bus.EXC_PC = pc; bus.ERET = eret;
    lat = 0;
    do begin
      @(negedge CLK);
      bus.ERET = 1'b0;
      lat++;
    end while (!bus.EXC_ACK && lat < 10);
    taken  = bus.EXC_TAKEN;
    target = bus.EXC_TARGET;
    bus.EXC_REQ = 1'b0;
    @(negedge CLK);
    $display("txn exc code %0d pc %h lat %0d taken %0b target %h", code, pc, lat, taken, target);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    idle_inputs();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    exp_q.push_back(32'h0000_000F); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    read_reg(5'd12, d); exp = exp_q.pop_front(); checks++;
    if (d !== exp) begin errors++; $display("FAIL reset_status got %h exp %h", d, exp); end
    read_reg(5'd13, d); exp = exp_q.pop_front(); checks++;
    if (d !== exp) begin errors++; $display("FAIL reset_cause got %h exp %h", d, exp); end
    read_reg(5'd14, d); exp = exp_q.pop_front(); checks++;
    if (d !== exp) begin errors++; $display("FAIL reset_epc got %h exp %h", d, exp); end
    read_reg(5'd5, d); exp = exp_q.pop_front(); checks++;
    if (d !== exp) begin errors++; $display("FAIL reset_addr5 got %h exp %h", d, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'h0, bus.EXC_ACK} !== exp) begin errors++; $display("FAIL reset_ack got %b exp %h", bus.EXC_ACK, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'h0, bus.EXC_TAKEN} !== exp) begin errors++; $display("FAIL reset_taken got %b exp %h", bus.EXC_TAKEN, exp); end
    $display("txn reset done");
  endtask

  task automatic test_mtc0();
    logic [31:0] d;
    mtc0(5'd14, 32'h1234_5678);
    exp_q.push_back(32'h1234_5678); exp_q.push_back(32'h1234_5678);
    read_reg(5'd14, d); exp = exp_q.pop_front(); checks++;
    if (d !== exp) begin errors++; $display("FAIL mtc0_epc_read got %h exp %h", d, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.EPC_OUT !== exp) begin errors++; $display("FAIL mtc0_epc_out got %h exp %h", bus.EPC_OUT, exp); end
    mtc0(5'd5, 32'hDEAD_BEEF);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0000_000F);
    read_reg(5'd5, d); exp = exp_q.pop_front(); checks++;
    if (d !== exp) begin errors++; $display("FAIL mtc0_drop_addr5 got %h exp %h", d, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.STATUS_OUT !== exp) begin errors++; $display("FAIL mtc0_drop_status got %h exp %h", bus.STATUS_OUT, exp); end
  endtask

  task automatic test_exception();
    int lat; logic taken; logic [31:0] target, d;
    exp_q.push_back(32'd3); exp_q.push_back(32'd1); exp_q.push_back(32'h0040_0004);
    exp_q.push_back(32'h0040_0100); exp_q.push_back(32'h20); exp_q.push_back(32'h1E0);
    do_exc(5'd8, 32'h0040_0100, 1'b0, lat, taken, target);
    exp = exp_q.pop_front(); checks++;
    if (lat !== int'(exp)) begin errors++; $display("FAIL exc_latency got %0d exp %0d", lat, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'h0, taken} !== exp) begin errors++; $display("FAIL exc_taken got %b exp %h", taken, exp); end
    exp = exp_q.pop_front(); checks++;
    if (target !== exp) begin errors++; $display("FAIL exc_target got %h exp %h", target, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.EPC_OUT !== exp) begin errors++; $display("FAIL exc_epc got %h exp %h", bus.EPC_OUT, exp); end
    read_reg(5'd13, d); exp = exp_q.pop_front(); checks++;
    if (d !== exp) begin errors++; $display("FAIL exc_cause got %h exp %h", d, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.STATUS_OUT !== exp) begin errors++; $display("FAIL exc_status got %h exp %h", bus.STATUS_OUT, exp); end
  endtask

  task automatic test_eret();
    exp_q.push_back(32'h0000_000F); exp_q.push_back(32'h0040_0100); exp_q.push_back(32'h0);
    @(negedge CLK); bus.ERET = 1'b1;
    @(negedge CLK); bus.ERET = 1'b0;
    $display("txn eret status %h target %h", bus.STATUS_OUT, bus.EXC_TARGET);
    exp = exp_q.pop_front(); checks++;
    if (bus.STATUS_OUT !== exp) begin errors++; $display("FAIL eret_status got %h exp %h", bus.STATUS_OUT, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.EXC_TARGET !== exp) begin errors++; $display("FAIL eret_target got %h exp %h", bus.EXC_TARGET, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'h0, bus.EXC_ACK} !== exp) begin errors++; $display("FAIL eret_ack got %b exp %h", bus.EXC_ACK, exp); end
  endtask

  task automatic test_masked();
    int lat; logic taken; logic [31:0] target, d;
    mtc0(5'd12, 32'h0000_000B);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'h0040_0100);
    exp_q.push_back(32'h0040_0100); exp_q.push_back(32'h20); exp_q.push_back(32'h0B);
    do_exc(5'd9, 32'h0040_0300, 1'b0, lat, taken, target);
    exp = exp_q.pop_front(); checks++;
    if (lat !== int'(exp)) begin errors++; $display("FAIL masked_latency got %0d exp %0d", lat, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'h0, taken} !== exp) begin errors++; $display("FAIL masked_taken got %b exp %h", taken, exp); end
    exp = exp_q.pop_front(); checks++;
    if (target !== exp) begin errors++; $display("FAIL masked_target got %h exp %h", target, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.EPC_OUT !== exp) begin errors++; $display("FAIL masked_epc got %h exp %h", bus.EPC_OUT, exp); end
    read_reg(5'd13, d); exp = exp_q.pop_front(); checks++;
    if (d !== exp) begin errors++; $display("FAIL masked_cause got %h exp %h", d, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.STATUS_OUT !== exp) begin errors++; $display("FAIL masked_status got %h exp %h", bus.STATUS_OUT, exp); end
  endtask

  task automatic test_bad_code();
    int lat; logic taken; logic [31:0] target;
    mtc0(5'd12, 32'h0000_000F);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'h0F);
    do_exc(5'd4, 32'h0040_0400, 1'b0, lat, taken, target);
    exp = exp_q.pop_front(); checks++;
    if (lat !== int'(exp)) begin errors++; $display("FAIL badcode_latency got %0d exp %0d", lat, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'h0, taken} !== exp) begin errors++; $display("FAIL badcode_taken got %b exp %h", taken, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.STATUS_OUT !== exp) begin errors++; $display("FAIL badcode_status got %h exp %h", bus.STATUS_OUT, exp); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    exp_q.push_back(32'h0F); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge CLK);
    bus.EXC_REQ = 1'b1; bus.EXC_CODE = 5'd13; bus.EXC_PC = 32'h0040_0500;
    @(negedge CLK);             // SAVE
    @(negedge CLK);             // SHIFT
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1; bus.EXC_REQ = 1'b0;
    $display("txn reset_mid status %h epc %h ack %b", bus.STATUS_OUT, bus.EPC_OUT, bus.EXC_ACK);
    exp = exp_q.pop_front(); checks++;
    if (bus.STATUS_OUT !== exp) begin errors++; $display("FAIL rstmid_status got %h exp %h", bus.STATUS_OUT, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.EPC_OUT !== exp) begin errors++; $display("FAIL rstmid_epc got %h exp %h", bus.EPC_OUT, exp); end
    read_reg(5'd13, d); exp = exp_q.pop_front(); checks++;
    if (d !== exp) begin errors++; $display("FAIL rstmid_cause got %h exp %h", d, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'h0, bus.EXC_ACK} !== exp) begin errors++; $display("FAIL rstmid_ack got %b exp %h", bus.EXC_ACK, exp); end
    @(negedge CLK);
    exp = exp_q.pop_front(); checks++;
    if ({31'h0, bus.EXC_ACK} !== exp) begin errors++; $display("FAIL rstmid_ack_after got %b exp %h", bus.EXC_ACK, exp); end
  endtask

  task automatic test_req_eret();
    int lat; logic taken; logic [31:0] target;
    exp_q.push_back(32'd3); exp_q.push_back(32'd1);
    exp_q.push_back(32'h1E0); exp_q.push_back(32'h0040_0200);
    do_exc(5'd8, 32'h0040_0200, 1'b1, lat, taken, target);
    exp = exp_q.pop_front(); checks++;
    if (lat !== int'(exp)) begin errors++; $display("FAIL reqeret_latency got %0d exp %0d", lat, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'h0, taken} !== exp) begin errors++; $display("FAIL reqeret_taken got %b exp %h", taken, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.STATUS_OUT !== exp) begin errors++; $display("FAIL reqeret_status got %h exp %h", bus.STATUS_OUT, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.EPC_OUT !== exp) begin errors++; $display("FAIL reqeret_epc got %h exp %h", bus.EPC_OUT, exp); end
  endtask

  initial begin
    test_reset();
    test_mtc0();
    test_exception();
    test_eret();
    test_masked();
    test_bad_code();
    test_reset_mid();
    test_req_eret();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
